// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM states and port indices
// for the two-port SRAM sequencing controller.
package sram_ctrl_pkg;
  localparam int AW = 6;
  localparam int DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARM,
    ACC,
    RESP
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;
endpackage

// File: rtl/sram_ctrl_if.sv
// Fetch and data request ports of the SRAM
// controller, bundled as one handshake interface.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/sram_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; on contention
// the port not granted last wins.
module rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_dm,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req_if && !req_dm): gnt = 2'b01;
      (!req_if && req_dm): gnt = 2'b10;
      (req_if && req_dm):
        gnt = (last == PORT_IF) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// Arbitrates fetch/data ports onto the SRAM and
// drives its pins through PRE/ARM/ACC/RESP.
module sram_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  sram_ctrl_if.slave    bus,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_datain,
  input  logic [DW-1:0] sram_dataout,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] sa_q, sa_d;
  logic [DW-1:0] din_q, din_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rd_q, if_rd_d;
  logic [DW-1:0] dm_rd_q, dm_rd_d;
  logic          busy_q, busy_d;
  logic [1:0]    gnt;

  rr_arbiter2 u_arb (
    .req_if (bus.if_req),
    .req_dm (bus.dm_req),
    .last   (last_q),
    .gnt    (gnt)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sa_d     = sa_q;
    din_d    = din_q;
    cs_d     = cs_q;
    wr_d     = wr_q;
    if_ack_d = 1'b0;
    dm_ack_d = 1'b0;
    if_rd_d  = if_rd_q;
    dm_rd_d  = dm_rd_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: if (gnt != 2'b00) begin
        state_d = PRE;
        busy_d  = 1'b1;
        port_d  = gnt[1] ? PORT_DM : PORT_IF;
        last_d  = port_d;
        addr_d  = gnt[1] ? bus.dm_addr : bus.if_addr;
        wdata_d = gnt[1] ? bus.dm_wdata : '0;
        op_d    = gnt[1] ? !bus.dm_we : 1'b1;
        // park on ~a so ACC is always an address change
        sa_d    = ~addr_d;
        din_d   = wdata_d;
        cs_d    = 1'b0;
        wr_d    = 1'b1;
      end
      PRE: begin
        state_d = ARM;
        cs_d    = 1'b1;
        wr_d    = op_q;
      end
      ARM: begin
        state_d = ACC;
        sa_d    = addr_q;
      end
      ACC: begin
        state_d = RESP;
        cs_d    = 1'b0;
        wr_d    = 1'b1;
        if (port_q == PORT_IF) begin
          if_ack_d = 1'b1;
          if (op_q) if_rd_d = sram_dataout;
        end else begin
          dm_ack_d = 1'b1;
          if (op_q) dm_rd_d = sram_dataout;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= PORT_DM;
      port_q   <= PORT_IF;
      op_q     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      sa_q     <= '0;
      din_q    <= '0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b1;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      if_rd_q  <= '0;
      dm_rd_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sa_q     <= sa_d;
      din_q    <= din_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      if_ack_q <= if_ack_d;
      dm_ack_q <= dm_ack_d;
      if_rd_q  <= if_rd_d;
      dm_rd_q  <= dm_rd_d;
      busy_q   <= busy_d;
    end
  end

  assign sram_addr    = sa_q;
  assign sram_datain  = din_q;
  assign sram_cs      = cs_q;
  assign sram_wr      = wr_q;
  assign busy         = busy_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign bus.if_rdata = if_rd_q;
  assign bus.dm_rdata = dm_rd_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with an edge-sensitive
// SRAM model and an ack-ordered scoreboard.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  typedef struct {
    logic          port;
    logic          we;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_datain;
  logic [DW-1:0] sram_dataout;
  logic          sram_cs;
  logic          sram_wr;
  logic          busy;

  always #5 clk = ~clk;

  sram_ctrl_if bus ();

  sram_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sram_addr    (sram_addr),
    .sram_datain  (sram_datain),
    .sram_dataout (sram_dataout),
    .sram_cs      (sram_cs),
    .sram_wr      (sram_wr),
    .busy         (busy)
  );

  // SRAM acts only when the address changes while selected
  logic [DW-1:0] mem [64];
  logic [AW-1:0] prev_addr;
  bit            loaded = 1'b0;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0]       = 16'h4235;
      prev_addr    = '0;
      sram_dataout = '0;
      loaded       = 1'b1;
    end else begin
      if (sram_cs === 1'b1 && sram_addr !== prev_addr) begin
        if (sram_wr) sram_dataout = mem[sram_addr];
        else mem[sram_addr] = sram_datain;
      end
      prev_addr = sram_addr;
    end
  end

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] if_model;
  logic [DW-1:0] dm_model;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h",
                tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cs"}, sram_cs, 1'b0);
    check({tag, "_wr"}, sram_wr, 1'b1);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_din"}, sram_datain, 0);
    check({tag, "_ifack"}, bus.if_ack, 1'b0);
    check({tag, "_dmack"}, bus.dm_ack, 1'b0);
    check({tag, "_ifrd"}, bus.if_rdata, 0);
    check({tag, "_dmrd"}, bus.dm_rdata, 0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic issue_if(input logic [AW-1:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    exp_q.push_back('{PORT_IF, 1'b0, ref_mem[a]});
  endtask

  task automatic issue_dm(input logic we,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    exp_q.push_back('{PORT_DM, we, ref_mem[a]});
    if (we) ref_mem[a] = d;
  endtask

  task automatic wait_ack(input int exp_lat,
                          input string tag);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = (bus.if_ack === 1'b1) ||
             (bus.dm_ack === 1'b1);
    end
    check({tag, "_ack"}, seen, 1'b1);
    check({tag, "_lat"}, n, exp_lat);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{PORT_IF, 1'b0, '0};
    check({tag, "_port"}, {bus.dm_ack, bus.if_ack},
          (e.port == PORT_DM) ? 2'b10 : 2'b01);
    if (e.port == PORT_IF) if_model = e.rdata;
    else if (!e.we) dm_model = e.rdata;
    check({tag, "_ifrd"}, bus.if_rdata, if_model);
    check({tag, "_dmrd"}, bus.dm_rdata, dm_model);
    if (e.port == PORT_IF) bus.if_req = 1'b0;
    else bus.dm_req = 1'b0;
    @(negedge clk);
    check({tag, "_ackdrop"},
          {bus.dm_ack, bus.if_ack}, 2'b00);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    ref_mem[0] = 16'h4235;
    if_model   = '0;
    dm_model   = '0;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    issue_if(6'h00);
    wait_ack(4, "preload");

    issue_dm(1'b1, 6'h10, 16'hBEEF);
    wait_ack(4, "wr10");
    issue_dm(1'b0, 6'h10, 16'h0);
    wait_ack(4, "rd10");

    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] v;
      v = (k == 0) ? 16'h1111 : 16'h2222;
      issue_dm(1'b1, 6'h3F, v);
      @(negedge clk);
      check("pre_addr", sram_addr, 6'h00);
      check("pre_cs", sram_cs, 1'b0);
      check("pre_busy", busy, 1'b1);
      @(negedge clk);
      check("arm_addr", sram_addr, 6'h00);
      check("arm_cs", sram_cs, 1'b1);
      check("arm_wr", sram_wr, 1'b0);
      check("arm_din", sram_datain, v);
      wait_ack(2, "wr3f");
    end
    issue_dm(1'b0, 6'h3F, 16'h0);
    wait_ack(4, "rd3f");

    issue_if(6'h01);
    issue_dm(1'b0, 6'h10, 16'h0);
    wait_ack(4, "cont_if");
    issue_if(6'h00);
    wait_ack(4, "cont_dm");
    wait_ack(4, "cont_if2");

    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 6'h05;
    bus.dm_wdata = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    check("rarm_cs", sram_cs, 1'b1);
    rst        = 1'b1;
    bus.dm_req = 1'b0;
    @(negedge clk);
    check_reset("rst_arm");
    if_model = '0;
    dm_model = '0;
    rst      = 1'b0;
    issue_dm(1'b0, 6'h05, 16'h0);
    wait_ack(4, "rd05");

    issue_dm(1'b0, 6'h10, 16'h0);
    wait_ack(4, "rd10b");
    issue_if(6'h00);
    wait_ack(4, "rd0b");

    bus.if_req  = 1'b1;
    bus.if_addr = 6'h00;
    repeat (3) @(negedge clk);
    check("racc_addr", sram_addr, 6'h00);
    check("racc_cs", sram_cs, 1'b1);
    rst        = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    check_reset("rst_acc");
    if_model = '0;
    dm_model = '0;
    rst      = 1'b0;

    issue_if(6'h3F);
    issue_dm(1'b0, 6'h10, 16'h0);
    wait_ack(4, "post_if");
    wait_ack(4, "post_dm");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
